// File: rtl/rf_pkg.sv
// Shared definitions for the register-file read port: register count,
// index/data widths and the read-port FSM state type.
package rf_pkg;

  localparam int unsigned RF_NUM_REGS = 16;
  localparam int unsigned RF_IDX_W    = 4;
  localparam int unsigned RF_DATA_W   = 32;
  localparam logic [RF_IDX_W-1:0] RF_LAST_IDX = 4'd15;

  typedef enum logic {
    RD_IDLE,
    RD_DUMP
  } rd_state_t;

endpackage

// File: rtl/rf_read_mux.sv
// Combinational 16:1 register selector with a bypass override. When bypass is
// high the override data is returned instead of the selected register.
module rf_read_mux
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_W
) (
  input  logic [DATA_WIDTH-1:0] q [RF_NUM_REGS],
  input  logic [RF_IDX_W-1:0]   sel,
  input  logic                  bypass,
  input  logic [DATA_WIDTH-1:0] bypass_data,
  output logic [DATA_WIDTH-1:0] data
);

  // Select the indexed register unless the bypass override is active.
  always_comb begin
    data = q[sel];
    if (bypass) begin
      data = bypass_data;
    end
  end

endmodule

// File: rtl/regfile_read_port.sv
// Read-side port of the 16x32 register file: single-cycle indexed reads and a
// sequenced R0..R15 dump, both returned on one registered valid/data/idx
// channel. Optional build macro RF_WRITE_BYPASS_EN returns the data being
// written when the sampled register is written on the same edge.
module regfile_read_port
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_W
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] Q0,
  input  logic [DATA_WIDTH-1:0] Q1,
  input  logic [DATA_WIDTH-1:0] Q2,
  input  logic [DATA_WIDTH-1:0] Q3,
  input  logic [DATA_WIDTH-1:0] Q4,
  input  logic [DATA_WIDTH-1:0] Q5,
  input  logic [DATA_WIDTH-1:0] Q6,
  input  logic [DATA_WIDTH-1:0] Q7,
  input  logic [DATA_WIDTH-1:0] Q8,
  input  logic [DATA_WIDTH-1:0] Q9,
  input  logic [DATA_WIDTH-1:0] Q10,
  input  logic [DATA_WIDTH-1:0] Q11,
  input  logic [DATA_WIDTH-1:0] Q12,
  input  logic [DATA_WIDTH-1:0] Q13,
  input  logic [DATA_WIDTH-1:0] Q14,
  input  logic [DATA_WIDTH-1:0] Q15,
  input  logic [15:0]           write,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  rd_req,
  input  logic [3:0]            rd_sel,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [3:0]            rd_idx,
  input  logic                  dump_start,
  output logic                  dump_busy,
  output logic                  dump_done
);

  rd_state_t             state, state_next;
  logic [RF_IDX_W-1:0]   cnt, cnt_next;
  logic                  capture;
  logic                  done_next;
  logic [RF_IDX_W-1:0]   mux_sel;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] mux_data;
  logic [DATA_WIDTH-1:0] q_all [RF_NUM_REGS];

  // Gather the discrete register ports into an indexable array.
  always_comb begin
    q_all[0]  = Q0;
    q_all[1]  = Q1;
    q_all[2]  = Q2;
    q_all[3]  = Q3;
    q_all[4]  = Q4;
    q_all[5]  = Q5;
    q_all[6]  = Q6;
    q_all[7]  = Q7;
    q_all[8]  = Q8;
    q_all[9]  = Q9;
    q_all[10] = Q10;
    q_all[11] = Q11;
    q_all[12] = Q12;
    q_all[13] = Q13;
    q_all[14] = Q14;
    q_all[15] = Q15;
  end

  assign rd_ready  = (state == RD_IDLE) & ~dump_start;
  assign dump_busy = (state == RD_DUMP);
  assign mux_sel   = (state == RD_DUMP) ? cnt : rd_sel;

`ifdef RF_WRITE_BYPASS_EN
  assign bypass = write[mux_sel];
`else
  logic unused_bypass_inputs;
  assign bypass               = 1'b0;
  assign unused_bypass_inputs = ^{write, D};
`endif

  rf_read_mux #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .q          (q_all),
    .sel        (mux_sel),
    .bypass     (bypass),
    .bypass_data(D),
    .data       (mux_data)
  );

  // Next-state, dump counter and capture decisions.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      RD_IDLE: begin
        if (dump_start) begin
          state_next = RD_DUMP;
          cnt_next   = '0;
        end else if (rd_req) begin
          capture = 1'b1;
        end
      end
      RD_DUMP: begin
        capture = 1'b1;
        if (cnt == RF_LAST_IDX) begin
          state_next = RD_IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      default: state_next = RD_IDLE;
    endcase
  end

  // FSM state and dump counter registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= RD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Output channel registers; data and index hold while no item is returned.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_idx    <= '0;
      dump_done <= 1'b0;
    end else begin
      rd_valid  <= capture;
      dump_done <= done_next;
      if (capture) begin
        rd_data <= mux_data;
        rd_idx  <= mux_sel;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// Self-checking bench for regfile_read_port: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_regfile_read_port;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] q [16];
  logic [15:0] write;
  logic [31:0] D;
  logic        rd_req;
  logic [3:0]  rd_sel;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  rd_idx;
  logic        dump_start;
  logic        dump_busy;
  logic        dump_done;

  int total = 0;
  int bad   = 0;

  // Reference model: pending dump indices plus expected output registers.
  int          dq[$];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data  = '0;
  logic [3:0]  exp_idx   = '0;
  logic        exp_done  = 1'b0;

  always #5 clk = ~clk;

  regfile_read_port #(.DATA_WIDTH(32)) dut (
    .clk(clk), .clr(clr),
    .Q0(q[0]), .Q1(q[1]), .Q2(q[2]), .Q3(q[3]),
    .Q4(q[4]), .Q5(q[5]), .Q6(q[6]), .Q7(q[7]),
    .Q8(q[8]), .Q9(q[9]), .Q10(q[10]), .Q11(q[11]),
    .Q12(q[12]), .Q13(q[13]), .Q14(q[14]), .Q15(q[15]),
    .write(write), .D(D),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_idx(rd_idx),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] value_of(input int idx);
`ifdef RF_WRITE_BYPASS_EN
    if (write[idx]) return D;
`endif
    return q[idx];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'b0, rd_valid}, {31'b0, exp_valid});
    chk({tag, ".data"}, rd_data, exp_data);
    chk({tag, ".idx"}, {28'b0, rd_idx}, {28'b0, exp_idx});
    chk({tag, ".done"}, {31'b0, dump_done}, {31'b0, exp_done});
    chk({tag, ".busy"}, {31'b0, dump_busy}, {31'b0, (dq.size() != 0)});
    chk({tag, ".ready"}, {31'b0, rd_ready}, {31'b0, (dq.size() == 0) && !dump_start});
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge.
  task automatic tick(input string tag);
    if (dq.size() != 0) begin
      int i;
      i = dq.pop_front();
      exp_valid = 1'b1;
      exp_data  = value_of(i);
      exp_idx   = 4'(i);
      exp_done  = (dq.size() == 0);
    end else if (dump_start) begin
      for (int i = 0; i < 16; i++) dq.push_back(i);
      exp_valid = 1'b0;
      exp_done  = 1'b0;
    end else if (rd_req) begin
      exp_valid = 1'b1;
      exp_data  = value_of(int'(rd_sel));
      exp_idx   = rd_sel;
      exp_done  = 1'b0;
    end else begin
      exp_valid = 1'b0;
      exp_done  = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    dq.delete();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_idx   = '0;
    exp_done  = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    clr = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int n;
    // Reset with a read request pending.
    clr = 1'b1; rd_req = 1'b1; rd_sel = 4'd2; dump_start = 1'b0;
    write = '0; D = '0;
    for (int i = 0; i < 16; i++) q[i] = 32'h0;
    @(posedge clk); #1;
    check_all("reset");
    chk("reset.data_const", rd_data, 32'h0);
    @(negedge clk);
    clr = 1'b0; rd_req = 1'b0;

    // Single read.
    q[5] = 32'hDEADBEEF; rd_req = 1'b1; rd_sel = 4'd5;
    tick("single");
    chk("single.data_const", rd_data, 32'hDEADBEEF);
    rd_req = 1'b0;
    tick("single_after");

    // Back-to-back reads.
    for (int i = 0; i < 16; i++) q[i] = 32'(i) * 32'h11111111;
    for (int i = 1; i <= 3; i++) begin
      rd_req = 1'b1; rd_sel = 4'(i);
      tick("b2b");
    end
    chk("b2b.data_const", rd_data, 32'h33333333);
    rd_req = 1'b0;
    tick("b2b_after");

    // Dump with reads requested throughout.
    for (int i = 0; i < 16; i++) q[i] = 32'h100 + 32'(i);
    dump_start = 1'b1; rd_req = 1'b1; rd_sel = 4'd9;
    tick("dump_start");
    dump_start = 1'b0;
    for (int i = 0; i < 16; i++) tick("dump");
    chk("dump.last_const", rd_data, 32'h10F);
    rd_req = 1'b0;
    tick("dump_after");

    // Same-edge write/read collision on R3.
    q[3] = 32'h00000033; write = 16'h0008; D = 32'hCAFEF00D;
    rd_req = 1'b1; rd_sel = 4'd3;
    tick("collide");
`ifdef RF_WRITE_BYPASS_EN
    chk("collide.const", rd_data, 32'hCAFEF00D);
`else
    chk("collide.const", rd_data, 32'h00000033);
`endif
    rd_req = 1'b0; write = '0;
    tick("collide_after");

    // Reset mid-dump after the idx 6 item, then a full dump again.
    dump_start = 1'b1;
    tick("mid_start");
    dump_start = 1'b0;
    n = 0;
    while (!(rd_valid && rd_idx == 4'd6) && n < 20) begin
      tick("mid_run");
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $error("FAIL mid_wait observed=timeout expected=idx6");
    end
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge clk);
    clr = 1'b0;
    dump_start = 1'b1;
    tick("redump_start");
    dump_start = 1'b0;
    for (int i = 0; i < 17; i++) tick("redump");

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      rd_req     = 1'($urandom_range(0, 1));
      rd_sel     = 4'($urandom_range(0, 15));
      dump_start = ($urandom_range(0, 19) == 0);
      write      = ($urandom_range(0, 2) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
      D          = $urandom;
      q[$urandom_range(0, 15)] = $urandom;
      if ($urandom_range(0, 149) == 0) do_reset("rand_reset");
      else tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
Read-side companion to the 16x32 register file. It accepts indexed read requests and returns the selected register value one cycle later through a registered valid/data/index channel. It also runs a sequenced dump that streams R0..R15 out on the same channel for debug and test benches. It sits between the register-file outputs Q0..Q15 and the consumers: bus-source logic, debug capture, and the bench scoreboard.

Parameters:
DATA_WIDTH, 32, width of every register value and of rd_data.
(Register count is fixed at 16; index width is fixed at 4.)

Ports:
clk  input  1  system clock, rising edge
clr  input  1  reset: asynchronous, active-high
Q0..Q15  input  DATA_WIDTH each  current register-file contents
write  input  16  one-hot register write enables, same-cycle view of the file's write port
D  input  DATA_WIDTH  write data presented to the file this cycle
rd_req  input  1  read request, accepted when rd_ready=1
rd_sel  input  4  register index to read
rd_ready  output  1  block can accept rd_req this cycle
rd_valid  output  1  rd_data/rd_idx valid this cycle (one-cycle pulse per item)
rd_data  output  DATA_WIDTH  returned register value
rd_idx  output  4  index of the returned register
dump_start  input  1  start a full 16-register dump
dump_busy  output  1  dump in progress
dump_done  output  1  one-cycle pulse coinciding with the final dump item

Behaviour:
- Clock/reset: one clock (clk); clr is asynchronous, active-high.
- Reset values: state RD_IDLE, dump counter 0, rd_valid 0, rd_data 0, rd_idx 0, dump_done 0. dump_busy is 0 and rd_ready is 1, both derived from state.
- Reset mid-dump: abort immediately, with no dump_done pulse. The next dump restarts at index 0.
- rd_ready = (state==RD_IDLE) & ~dump_start. It is combinational.
- RD_IDLE, rd_req & rd_ready at edge E:
  - At E, capture Q[rd_sel] into rd_data and rd_sel into rd_idx, and set rd_valid=1.
  - Latency is 1 cycle.
  - Back-to-back requests are accepted every cycle.
  - There is no output backpressure.
- RD_IDLE, dump_start at edge E0:
  - State goes to RD_DUMP, counter=0.
  - A same-cycle rd_req is not accepted.
- RD_DUMP, at each edge:
  - Capture Q[cnt] into rd_data and cnt into rd_idx, and set rd_valid=1.
  - If cnt==15: go to RD_IDLE and set dump_done=1 for that cycle.
  - Otherwise: cnt=cnt+1.
- Dump timing:
  - Items for R0..R15 appear on 16 consecutive cycles.
  - dump_done is high together with idx 15.
  - 17 edges elapse from dump_start to return to idle.
- dump_busy = (state==RD_DUMP).
- In RD_DUMP, rd_ready=0, and both rd_req and dump_start are ignored.
- rd_valid is low on every cycle not described above.
- rd_data and rd_idx hold their last value while rd_valid=0.
- Same-edge write/read collision, default: the returned value is the old register content, i.e. Q at the sampling edge.
- R0: the value presented on Q0 is returned unchanged. Zero-forcing of R0 is done upstream.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: if write[idx] is high at the sampling edge (idx = rd_sel for reads, cnt for dumps), rd_data captures D instead of Q[idx]. The returned value is then the value being written.
- Undefined: write and D are unused, and the old value is returned.
- Latency and handshake are unchanged in both builds.

Decomposition:
- Package rf_pkg contains:
  - RF_NUM_REGS=16, RF_IDX_W=4, RF_DATA_W=32, RF_LAST_IDX=4'd15.
  - typedef enum rd_state_t {RD_IDLE, RD_DUMP}.
- Sub-module rf_read_mux: combinational 16:1 selector of Q0..Q15 by index, with a bypass override input.
- The top level holds the FSM, the dump counter and the output registers.

Test Plan:
- Reset: clr=1 with rd_req=1, sel=2 -> rd_valid=0, rd_data=0, rd_idx=0, rd_ready=1, dump_busy=0.
- Single read: Q5=0xDEADBEEF, rd_req=1, sel=5 for one cycle -> next cycle rd_valid=1, rd_data=0xDEADBEEF, rd_idx=5; the cycle after, rd_valid=0.
- Back-to-back reads: Qn=n*0x11111111, requests sel 1,2,3 on consecutive cycles -> three consecutive valid cycles returning 0x11111111, 0x22222222, 0x33333333 with idx 1,2,3.
- Dump:
  - Stimulus: Qn=0x100+n, dump_start pulse plus rd_req=1 on the same cycle and during the dump.
  - Response: 16 consecutive valid cycles with idx 0..15 and data 0x100..0x10F.
  - dump_done is high only with idx 15; rd_ready=0 throughout; no extra read item.
- Collision: write=0x0008, D=0xCAFEF00D, Q3=0x00000033, read sel=3 on the same edge -> rd_data=0x00000033 without RF_WRITE_BYPASS_EN, 0xCAFEF00D with it.
- Reset mid-dump: assert clr after the idx 6 item -> outputs zero immediately, dump_busy=0, no dump_done; a new dump_start streams idx 0..15 again.
